// File: rtl/dmem_bridge.sv
// Bridge between the core's MEM-stage data port and a req/gnt + rvalid data bus.
// Handles one load/store at a time and reports completion, or failure, with a one-cycle pulse.
module dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ip_data_addr,
  input  logic        ip_data_wr,
  input  logic        ip_data_rd,
  input  logic [3:0]  ip_data_mask,
  input  logic [31:0] ip_data_from_proc,
  output logic        op_data_valid,
  output logic [31:0] op_data_to_proc,
  output logic        op_data_err,
  output logic        op_busy,
  output logic        op_bus_req,
  output logic        op_bus_we,
  output logic [31:0] op_bus_addr,
  output logic [3:0]  op_bus_wmask,
  output logic [31:0] op_bus_wdata,
  input  logic        ip_bus_gnt,
  input  logic        ip_bus_rvalid,
  input  logic [31:0] ip_bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TIMEOUT_LIM = TIMEOUT_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t      state;
  logic [31:2] addr_q;
  logic [3:0]  mask_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [31:0] tcount;
  logic        mask_ok;
  logic        legal;
  logic        timeout_hit;

  always_comb begin
    mask_ok = 1'b0;
    case (ip_data_mask)
      4'b1111:                         mask_ok = (ip_data_addr[1:0] == 2'b00);
      4'b0011, 4'b1100:                mask_ok = ~ip_data_addr[0];
      4'b0001, 4'b0010, 4'b0100, 4'b1000: mask_ok = 1'b1;
      default:                         mask_ok = 1'b0;
    endcase
    legal = mask_ok & ~(ip_data_rd & ip_data_wr);
  end

  // tcount holds the number of completed REQ/WAIT_R cycles, so the current one is the last allowed when it hits TIMEOUT_LIM.
  assign timeout_hit = TIMEOUT_EN && (tcount >= TIMEOUT_LIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      addr_q          <= '0;
      mask_q          <= '0;
      wdata_q         <= '0;
      we_q            <= 1'b0;
      tcount          <= '0;
      op_data_valid   <= 1'b0;
      op_data_err     <= 1'b0;
      op_data_to_proc <= '0;
      op_busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ip_data_rd | ip_data_wr) begin
            addr_q  <= ip_data_addr[31:2];
            mask_q  <= ip_data_mask;
            wdata_q <= ip_data_from_proc;
            we_q    <= ip_data_wr;
            tcount  <= '0;
            op_busy <= 1'b1;
            if (legal) begin
              state <= REQ;
            end else begin
              state           <= RESP;
              op_data_valid   <= 1'b1;
              op_data_err     <= 1'b1;
              op_data_to_proc <= ERR_RDATA;
            end
          end
        end
        REQ: begin
          tcount <= tcount + 32'd1;
          if (ip_bus_gnt) begin
            if (we_q) begin
              state         <= RESP;
              op_data_valid <= 1'b1;
              op_data_err   <= 1'b0;
            end else begin
              state <= WAIT_R;
            end
          end else if (timeout_hit) begin
            state           <= RESP;
            op_data_valid   <= 1'b1;
            op_data_err     <= 1'b1;
            op_data_to_proc <= ERR_RDATA;
          end
        end
        WAIT_R: begin
          tcount <= tcount + 32'd1;
          if (ip_bus_rvalid) begin
            state           <= RESP;
            op_data_valid   <= 1'b1;
            op_data_err     <= 1'b0;
            op_data_to_proc <= ip_bus_rdata;
          end else if (timeout_hit) begin
            state           <= RESP;
            op_data_valid   <= 1'b1;
            op_data_err     <= 1'b1;
            op_data_to_proc <= ERR_RDATA;
          end
        end
        RESP: begin
          state         <= IDLE;
          op_data_valid <= 1'b0;
          op_data_err   <= 1'b0;
          op_busy       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus side comes straight from state and capture registers so reset drops the request without a clock.
  assign op_bus_req   = (state == REQ);
  assign op_bus_we    = we_q;
  assign op_bus_addr  = {addr_q, 2'b00};
  assign op_bus_wmask = mask_q;
  assign op_bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized scoreboard bench for dmem_bridge: a reference model predicts each response
// and a monitor process pops and compares whenever op_data_valid fires.
module tb_dmem_bridge;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ip_data_addr;
  logic        ip_data_wr;
  logic        ip_data_rd;
  logic [3:0]  ip_data_mask;
  logic [31:0] ip_data_from_proc;
  logic        op_data_valid;
  logic [31:0] op_data_to_proc;
  logic        op_data_err;
  logic        op_busy;
  logic        op_bus_req;
  logic        op_bus_we;
  logic [31:0] op_bus_addr;
  logic [3:0]  op_bus_wmask;
  logic [31:0] op_bus_wdata;
  logic        ip_bus_gnt;
  logic        ip_bus_rvalid;
  logic [31:0] ip_bus_rdata;

  dmem_bridge #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
    .clk(clk), .reset(reset),
    .ip_data_addr(ip_data_addr), .ip_data_wr(ip_data_wr), .ip_data_rd(ip_data_rd),
    .ip_data_mask(ip_data_mask), .ip_data_from_proc(ip_data_from_proc),
    .op_data_valid(op_data_valid), .op_data_to_proc(op_data_to_proc),
    .op_data_err(op_data_err), .op_busy(op_busy),
    .op_bus_req(op_bus_req), .op_bus_we(op_bus_we), .op_bus_addr(op_bus_addr),
    .op_bus_wmask(op_bus_wmask), .op_bus_wdata(op_bus_wdata),
    .ip_bus_gnt(ip_bus_gnt), .ip_bus_rvalid(ip_bus_rvalid), .ip_bus_rdata(ip_bus_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          start;
    int          lat;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] model_data;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every completion pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && op_data_valid === 1'b1) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_valid: got valid=1 want no response (t=%0t)", $time);
      end else begin
        e = expq.pop_front();
        check_output("resp_err", 32'(op_data_err), 32'(e.err));
        check_output("resp_data", op_data_to_proc, e.data);
        check_output("resp_latency", 32'(cyc - e.start), 32'(e.lat));
      end
    end
  end

  function automatic logic is_legal(input logic [31:0] a, input logic [3:0] m, input logic rd, input logic wr);
    if (rd && wr) return 1'b0;
    case (m)
      4'hF:                return (a % 4) == 0;
      4'h3, 4'hC:          return (a % 2) == 0;
      4'h1, 4'h2, 4'h4, 4'h8: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  // Reference timing, in cycles counted from the cycle the request is presented.
  // g/r are the REQ/WAIT_R cycle indices (0 = first REQ cycle) at which gnt/rvalid are driven.
  task automatic predict(input logic legal, input logic we, input int g, input int r,
                         output logic err, output int lat, output int reqc);
    int lim;
    if (!legal) begin
      err = 1'b1; lat = 1; reqc = 0;
    end else if (g >= TO) begin
      err = 1'b1; lat = TO + 1; reqc = TO;
    end else if (we) begin
      err = 1'b0; lat = g + 2; reqc = g + 1;
    end else begin
      lim  = (g + 1 > TO - 1) ? g + 1 : TO - 1;
      reqc = g + 1;
      if (r <= lim) begin
        err = 1'b0; lat = r + 2;
      end else begin
        err = 1'b1; lat = lim + 2;
      end
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic [3:0] m, input logic [31:0] wd,
                                input logic rd, input logic wr, input int g, input int r,
                                input logic [31:0] rdat);
    logic        legal, err, seen;
    int          lat, reqc, req_cnt, first_req, busy_bad, start;
    logic [31:0] edata;
    @(negedge clk);
    ip_data_addr = a; ip_data_mask = m; ip_data_from_proc = wd;
    ip_data_rd = rd; ip_data_wr = wr;
    ip_bus_gnt = 1'b0; ip_bus_rvalid = 1'b0;
    legal = is_legal(a, m, rd, wr);
    predict(legal, wr, g, r, err, lat, reqc);
    if (err)      edata = ERR;
    else if (!wr) edata = rdat;
    else          edata = model_data;
    model_data = edata;
    start = cyc;
    expq.push_back('{err, edata, start, lat});
    req_cnt = 0; first_req = -1; busy_bad = 0; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (op_bus_req) begin
        if (first_req < 0) first_req = cyc;
        req_cnt++;
        check_output("bus_addr", op_bus_addr, {a[31:2], 2'b00});
        check_output("bus_we", 32'(op_bus_we), 32'(wr));
        check_output("bus_wmask", 32'(op_bus_wmask), 32'(m));
        check_output("bus_wdata", op_bus_wdata, wd);
      end
      if (!op_busy) busy_bad++;
      if (op_data_valid) begin
        seen = 1'b1;
        ip_bus_gnt    = 1'($urandom_range(0, 1));
        ip_bus_rvalid = 1'($urandom_range(0, 1));
        ip_bus_rdata  = $urandom;
        break;
      end
      ip_bus_gnt    = (k == g);
      ip_bus_rvalid = (k == r);
      ip_bus_rdata  = (k == r) ? rdat : $urandom;
    end
    check_output("valid_seen", 32'(seen), 32'd1);
    check_output("req_cycles", 32'(req_cnt), 32'(reqc));
    if (legal) check_output("req_start", 32'(first_req), 32'(start + 1));
    check_output("busy_during", 32'(busy_bad), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ip_data_rd = 1'b0; ip_data_wr = 1'b0;
      check_output("idle_busy", 32'(op_busy), 32'd0);
      check_output("idle_req", 32'(op_bus_req), 32'd0);
      ip_bus_gnt    = 1'($urandom_range(0, 1));
      ip_bus_rvalid = 1'($urandom_range(0, 1));
      ip_bus_rdata  = $urandom;
    end
  endtask

  task automatic reset_mid(input logic in_wait);
    @(negedge clk);
    ip_data_addr = 32'h40; ip_data_mask = 4'hF; ip_data_rd = 1'b1; ip_data_wr = 1'b0;
    ip_bus_gnt = 1'b0; ip_bus_rvalid = 1'b0;
    @(negedge clk);
    check_output("rst_pre_req", 32'(op_bus_req), 32'd1);
    ip_bus_gnt = in_wait;
    if (in_wait) begin
      @(negedge clk);
      ip_bus_gnt = 1'b0;
      check_output("rst_wait_busy", 32'(op_busy), 32'd1);
    end
    #2 reset = 1'b0;
    #1;
    check_output("rst_async_req", 32'(op_bus_req), 32'd0);
    check_output("rst_async_busy", 32'(op_busy), 32'd0);
    ip_data_rd = 1'b0;
    model_data = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    ip_bus_rvalid = 1'b1; ip_bus_gnt = 1'b1; ip_bus_rdata = 32'h1234_5678;
    @(negedge clk);
    ip_bus_rvalid = 1'b0; ip_bus_gnt = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_output("late_rvalid_ignored", 32'(op_data_valid), 32'd0);
    end
    check_output("late_rvalid_data", op_data_to_proc, 32'd0);
  endtask

  task automatic random_txn();
    logic [3:0]  masks [10] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h5, 4'h0, 4'h6};
    logic [31:0] a;
    logic        rd, wr;
    int          g, sel;
    a   = $urandom;
    sel = $urandom_range(0, 9);
    rd  = (sel == 0) || (sel % 2 == 1);
    wr  = (sel == 0) || (sel % 2 == 0);
    g   = $urandom_range(0, 9);
    apply_stimulus(a, masks[$urandom_range(0, 9)], $urandom, rd, wr, g,
                   g + $urandom_range(1, 4), $urandom);
    idle($urandom_range(0, 2));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    ip_data_addr = '0; ip_data_wr = 1'b0; ip_data_rd = 1'b0; ip_data_mask = '0;
    ip_data_from_proc = '0; ip_bus_gnt = 1'b0; ip_bus_rvalid = 1'b0; ip_bus_rdata = '0;
    model_data = '0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_valid", 32'(op_data_valid), 32'd0);
    check_output("rst_err", 32'(op_data_err), 32'd0);
    check_output("rst_busy", 32'(op_busy), 32'd0);
    check_output("rst_req", 32'(op_bus_req), 32'd0);
    check_output("rst_we", 32'(op_bus_we), 32'd0);
    check_output("rst_addr", op_bus_addr, 32'd0);
    check_output("rst_wmask", 32'(op_bus_wmask), 32'd0);
    check_output("rst_wdata", op_bus_wdata, 32'd0);
    check_output("rst_rdata", op_data_to_proc, 32'd0);
    reset = 1'b1;

    reset_mid(1'b0);
    reset_mid(1'b1);

    apply_stimulus(32'h100, 4'hF, 32'h0, 1'b1, 1'b0, 0, 1, 32'hCAFE_F00D);
    idle(1);
    apply_stimulus(32'h203, 4'h8, 32'hAA00_0000, 1'b0, 1'b1, 4, 99, 32'h0);
    idle(1);
    apply_stimulus(32'h201, 4'h3, 32'h0000_5555, 1'b0, 1'b1, 0, 1, 32'h0);
    idle(1);
    apply_stimulus(32'h180, 4'hF, 32'h0, 1'b1, 1'b0, 0, 100, 32'h5A5A_5A5A);
    idle(1);
    apply_stimulus(32'h300, 4'hF, 32'h0, 1'b1, 1'b0, 0, 2, 32'h1357_9BDF);
    apply_stimulus(32'h304, 4'hF, 32'h2468_ACE0, 1'b0, 1'b1, 0, 99, 32'h0);
    idle(2);

    for (int n = 0; n < 60; n++) random_txn();
    idle(3);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("[TB] FAIL outstanding_responses: got %0d pending want 0", expq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
